// File: rtl/hack_alu_arbiter.sv
// Round-robin arbiter sharing one external combinational Hack ALU between two requesters.
// Optional grant statistics counters are enabled by defining HACK_ALU_ARB_STATS_EN.
module hack_alu_arbiter #(
   parameter int WIDTH         = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic [5:0]       req0_ctl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   input  logic [5:0]       req1_ctl,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_zr,
   output logic             rsp_ng,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_ctl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng
`ifdef HACK_ALU_ARB_STATS_EN
   ,
   output logic [15:0]      grant0_count,
   output logic [15:0]      grant1_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_RESP
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic             r_last_grant;
   logic             r_id;
   logic [WIDTH-1:0] r_alu_x;
   logic [WIDTH-1:0] r_alu_y;
   logic [5:0]       r_alu_ctl;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_out;
   logic             r_rsp_zr;
   logic             r_rsp_ng;

   logic             w_grant0;
   logic             w_grant1;
   logic             w_accept;
   logic             w_handshake;

   // On a tie the requester that was not served last wins.
   assign w_grant0    = req0_valid & (~req1_valid | r_last_grant);
   assign w_grant1    = req1_valid & (~req0_valid | ~r_last_grant);
   assign req0_ready  = (r_state == S_IDLE) & w_grant0;
   assign req1_ready  = (r_state == S_IDLE) & w_grant1;
   assign w_accept    = req0_ready | req1_ready;
   assign rsp_valid   = (r_state == S_RESP);
   assign w_handshake = rsp_valid & rsp_ready;

   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
         S_ISSUE:   if (r_cnt == CNT_LAST) w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_RESP;
         S_RESP:    if (w_handshake) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Operand registers drive the ALU and keep their value outside ISSUE to avoid toggling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= 4'd0;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_alu_x      <= '0;
         r_alu_y      <= '0;
         r_alu_ctl    <= 6'd0;
      end else if (w_accept) begin
         r_cnt        <= 4'd0;
         r_last_grant <= req1_ready;
         r_id         <= req1_ready;
         r_alu_x      <= req1_ready ? req1_x   : req0_x;
         r_alu_y      <= req1_ready ? req1_y   : req0_y;
         r_alu_ctl    <= req1_ready ? req1_ctl : req0_ctl;
      end else if (r_state == S_ISSUE) begin
         r_cnt        <= r_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_id  <= 1'b0;
         r_rsp_out <= '0;
         r_rsp_zr  <= 1'b0;
         r_rsp_ng  <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
         r_rsp_id  <= r_id;
         r_rsp_out <= alu_out;
         r_rsp_zr  <= alu_zr;
         r_rsp_ng  <= alu_ng;
      end
   end

   assign alu_x   = r_alu_x;
   assign alu_y   = r_alu_y;
   assign alu_ctl = r_alu_ctl;
   assign rsp_id  = r_rsp_id;
   assign rsp_out = r_rsp_out;
   assign rsp_zr  = r_rsp_zr;
   assign rsp_ng  = r_rsp_ng;

`ifdef HACK_ALU_ARB_STATS_EN
   logic [15:0] r_grant0_count;
   logic [15:0] r_grant1_count;

   // Free-running counters; wrap naturally from 0xFFFF to 0x0000.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant0_count <= 16'd0;
         r_grant1_count <= 16'd0;
      end else begin
         if (req0_ready) r_grant0_count <= r_grant0_count + 16'd1;
         if (req1_ready) r_grant1_count <= r_grant1_count + 16'd1;
      end
   end

   assign grant0_count = r_grant0_count;
   assign grant1_count = r_grant1_count;
`endif

endmodule
